// File: rtl/cordic_pkg.sv
// Shared constants, tag type and helpers for the CORDIC phase-preparation front end.
package cordic_pkg;

  localparam int                 CORDIC_W        = 16;
  localparam logic signed [31:0] PIO2_Q14        = 32'sd25736;
  localparam logic signed [15:0] CORDIC_GAIN_Q14 = 16'sd9949;
  localparam int                 CORDIC_LAT      = 16;

  typedef struct packed {
    logic valid;
    logic flip;
  } cordic_tag_t;

  // Negation that cannot overflow: the most negative code maps to the most positive.
  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
    return (v == 16'sh8000) ? 16'sh7fff : -v;
  endfunction

endpackage

// File: rtl/cordic_tag_delay.sv
// Fixed-depth shift register of {valid, flip} tags, matched to the CORDIC core latency.
module cordic_tag_delay
  import cordic_pkg::*;
#(
  parameter int DEPTH = 16
)(
  input  logic        clk,
  input  logic        reset_n,
  input  cordic_tag_t d,
  output cordic_tag_t q
);

  cordic_tag_t pipe [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/cordic_phase_prep.sv
// Phase reduction and operand drive for a rotation-mode CORDIC core, plus result tagging.
// Optional output negation stage is enabled by defining CORDIC_PREP_POSTFIX_EN.
module cordic_phase_prep
  import cordic_pkg::*;
#(
  parameter int                 WIDTH       = CORDIC_W,
  parameter int                 CORDIC_LAT  = cordic_pkg::CORDIC_LAT,
  parameter logic signed [15:0] CORDIC_GAIN = CORDIC_GAIN_Q14
)(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        phase_in,
  input  logic                    phase_valid,
  output logic signed [WIDTH-1:0] x_start,
  output logic signed [WIDTH-1:0] y_start,
  output logic signed [WIDTH-1:0] angle,
  output logic                    operands_val,
  output logic                    res_valid,
  output logic                    res_flip,
`ifdef CORDIC_PREP_POSTFIX_EN
  input  logic signed [WIDTH-1:0] cordic_sine,
  input  logic signed [WIDTH-1:0] cordic_cosine,
  output logic signed [WIDTH-1:0] sine_out,
  output logic signed [WIDTH-1:0] cosine_out,
`endif
  output logic [4:0]              occupancy
);

  logic                    valid_a;
  logic                    flip_a;
  logic signed [WIDTH-1:0] red_a;
  logic                    flip_in;
  logic                    flip_b;
  logic signed [31:0]      prod;
  logic signed [31:0]      prod_rnd;
  cordic_tag_t             tag_in;
  cordic_tag_t             tag_out;

  // Phases in quadrants 1 and 2 are rotated by pi so the core only sees [-pi/2, pi/2).
  assign flip_in = phase_in[15] ^ phase_in[14];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_a <= 1'b0;
      flip_a  <= 1'b0;
      red_a   <= '0;
    end else begin
      valid_a <= phase_valid;
      flip_a  <= phase_valid & flip_in;
      red_a   <= flip_in ? $signed(phase_in ^ 16'h8000) : $signed(phase_in);
    end
  end

  always_comb begin
    prod     = $signed({{16{red_a[15]}}, red_a}) * PIO2_Q14;
    prod_rnd = prod + 32'sd8192;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operands_val <= 1'b0;
      flip_b       <= 1'b0;
      x_start      <= '0;
      angle        <= '0;
    end else begin
      operands_val <= valid_a;
      flip_b       <= flip_a;
      x_start      <= valid_a ? CORDIC_GAIN : '0;
      angle        <= valid_a ? prod_rnd[29:14] : '0;
    end
  end

  assign y_start = '0;

  assign tag_in = {operands_val, flip_b};

  cordic_tag_delay #(.DEPTH(CORDIC_LAT)) u_tag_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (tag_in),
    .q       (tag_out)
  );

`ifdef CORDIC_PREP_POSTFIX_EN
  // Extra register stage keeps the flags aligned with the corrected results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid  <= 1'b0;
      res_flip   <= 1'b0;
      sine_out   <= '0;
      cosine_out <= '0;
    end else begin
      res_valid  <= tag_out.valid;
      res_flip   <= tag_out.flip;
      sine_out   <= tag_out.flip ? neg_sat(cordic_sine)   : cordic_sine;
      cosine_out <= tag_out.flip ? neg_sat(cordic_cosine) : cordic_cosine;
    end
  end
`else
  assign res_valid = tag_out.valid;
  assign res_flip  = tag_out.flip;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else begin
      case ({phase_valid, res_valid})
        2'b10:   occupancy <= occupancy + 5'd1;
        2'b01:   occupancy <= occupancy - 5'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: doc/cordic_phase_prep.md
Name: cordic_phase_prep

Overview:
- Front-end stage that feeds the 16-stage rotation-mode CORDIC core and tracks its results.
- Takes a full-turn unsigned phase word and reduces it to the core's convergent range, [-pi/2, pi/2), by a pi rotation.
- Converts the reduced phase to Q2.14 radians and drives the core's x_start/y_start/angle/operands_val.
- The core has no valid output, so a latency-matched tag pipeline produces result-valid and quadrant-flip flags aligned with the core's sine/cosine.

Parameters:
- WIDTH, 16, data/angle width; only 16 is supported (constants are 16-bit).
- CORDIC_LAT, 16, cycles from the core's operand inputs to its sine/cosine outputs.
- CORDIC_GAIN, 16'sd9949, 1/K (0.60725) in Q2.14; driven on x_start.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- phase_in  in  16  unsigned phase; 2^16 = one full turn (2*pi)
- phase_valid  in  1  phase_in is valid this cycle; no backpressure
- x_start  out  16  signed, to core
- y_start  out  16  signed, to core
- angle  out  16  signed Q2.14 radians, to core
- operands_val  out  1  operands valid, to core
- res_valid  out  1  core sine/cosine are valid this cycle
- res_flip  out  1  result must be negated (pi rotation applied)
- occupancy  out  5  tokens in flight (0..18)
- cordic_sine, cordic_cosine  in  16  core results (only with CORDIC_PREP_POSTFIX_EN)
- sine_out, cosine_out  out  16  corrected results (only with CORDIC_PREP_POSTFIX_EN)

Behaviour:
- Reset is asynchronous, active-low. Every output and register clears to 0, including x_start; x_start reloads CORDIC_GAIN only with a valid token.
- Stage A (registered, 1 cycle):
  - flip = phase_in[15] ^ phase_in[14].
  - red = flip ? phase_in ^ 16'h8000 : phase_in, interpreted as signed.
  - red is always in [-16384, 16383].
- Stage B (registered, 1 cycle):
  - prod = red * 25736 (pi/2 in Q2.14), 32-bit signed.
  - angle = (prod + 8192) >>> 14, truncated to 16 bits; range is [-25736, 25734].
  - x_start = CORDIC_GAIN, y_start = 0, operands_val = stage A valid.
  - When no token is present, x_start/y_start/angle hold 0.
- Tag pipe: CORDIC_LAT-deep shift register of {valid, flip}, loaded from stage B each cycle.
  - res_valid/res_flip = tail of the tag pipe.
  - Latency phase_valid -> res_valid = 2 + CORDIC_LAT = 18 cycles.
- Full throughput: one token per cycle; back-to-back and gapped streams preserve order and spacing.
- occupancy: +1 on phase_valid, -1 when res_valid is asserted; simultaneous in and out leave it unchanged. Maximum 18, never wraps.
- Reset mid-stream: all tokens are dropped and occupancy goes to 0. No res_valid is asserted for pre-reset tokens even though the core's own data pipe may still hold them.

Optional Feature:
- Macro CORDIC_PREP_POSTFIX_EN.
- Defined:
  - Adds cordic_sine/cordic_cosine inputs and sine_out/cosine_out outputs.
  - One extra register stage: out = res_flip ? -in : in, where -(-32768) saturates to 32767.
  - res_valid and res_flip are delayed one cycle to stay aligned: latency 19, occupancy maximum 19, so 5 bits is still sufficient.
  - sine_out/cosine_out reset to 0.
- Undefined: those ports are absent; res_flip is consumed externally.

Decomposition:
- Package cordic_pkg holds:
  - CORDIC_W = 16
  - PIO2_Q14 = 25736
  - CORDIC_GAIN_Q14 = 9949
  - CORDIC_LAT = 16
  - typedef cordic_tag_t = struct {logic valid; logic flip;}
- Sub-module cordic_tag_delay: parameterised-depth shift register of cordic_tag_t with async active-low reset.

Test Plan:
- phase_in 16'h0000 pulsed once -> cycle 2: operands_val=1, angle=0, x_start=9949, y_start=0; cycle 18: res_valid=1, res_flip=0; all other cycles res_valid=0.
- phase_in 16'h2000 (pi/4) -> angle=12868, flip=0. phase_in 16'h4000 (pi/2) -> angle=-25736, res_flip=1. phase_in 16'hC000 -> angle=-25736, flip=0.
- phase_in 16'h7FFF -> red=-1, angle=-2, flip=1. phase_in 16'h8000 -> red=0, angle=0, flip=1.
- 20 consecutive valid phases -> occupancy ramps 1..18, holds 18 while in and out overlap, drains to 0; res_valid high for exactly 20 contiguous cycles starting at cycle 18.
- reset_n low for 1 cycle at cycle 5 of a 10-token burst -> all outputs 0 immediately; after release, res_valid never asserts and occupancy=0.
- With CORDIC_PREP_POSTFIX_EN: cordic_sine=-32768, cordic_cosine=1000 on a flip token -> sine_out=32767, cosine_out=-1000 at cycle 19.
